// File: rtl/exhaustive_removal_ctrl.sv
// Iterative accessibility-rule sequencer: loads an occupancy grid row by row, then removes sparse cells pass by pass until a pass removes nothing.
// Optional pass cap: define EXHAUST_PASS_LIMIT_EN to add MAX_PASSES and the limit_hit output.
module exhaustive_removal_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(WIDTH*DEPTH+1),
    parameter int PASS_W = $clog2(WIDTH*DEPTH+2)
`ifdef EXHAUST_PASS_LIMIT_EN
    ,
    parameter int MAX_PASSES = 64
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              row_valid,
    output logic              row_ready,
    input  logic [WIDTH-1:0]  row_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  first_pass_removed,
    output logic [CNT_W-1:0]  total_removed,
    output logic [PASS_W-1:0] pass_count
`ifdef EXHAUST_PASS_LIMIT_EN
    ,
    output logic              limit_hit
`endif
);

    localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(WIDTH+1);
    localparam logic [RW-1:0] LAST_ROW = RW'(DEPTH-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] grid [DEPTH];
    logic [WIDTH-1:0] mask [DEPTH];
    logic [RW-1:0]    row_idx;
    logic [CNT_W-1:0] pass_removed;
    logic             first_commit;

    logic [RW-1:0]    prev_idx;
    logic [RW-1:0]    next_idx;
    logic [WIDTH+1:0] up_pad;
    logic [WIDTH+1:0] mid_pad;
    logic [WIDTH+1:0] dn_pad;
    logic [3:0]       nsum;
    logic [WIDTH-1:0] row_mask;
    logic [PW-1:0]    row_pop;

    // Neighbourhood of the current row; padding bits model out-of-range cells as empty.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        prev_idx = (row_idx == '0) ? row_idx : row_idx - RW'(1);
        next_idx = (row_idx == LAST_ROW) ? row_idx : row_idx + RW'(1);
        up_pad   = (row_idx == '0) ? '0 : {1'b0, grid[prev_idx], 1'b0};
        mid_pad  = {1'b0, grid[row_idx], 1'b0};
        dn_pad   = (row_idx == LAST_ROW) ? '0 : {1'b0, grid[next_idx], 1'b0};
        nsum     = '0;
        row_mask = '0;
        row_pop  = '0;
        for (int j = 0; j < WIDTH; j++) begin
            nsum = 4'(up_pad[j]) + 4'(up_pad[j+1]) + 4'(up_pad[j+2])
                 + 4'(mid_pad[j])                  + 4'(mid_pad[j+2])
                 + 4'(dn_pad[j])  + 4'(dn_pad[j+1]) + 4'(dn_pad[j+2]);
            row_mask[j] = mid_pad[j+1] && (nsum < 4'd4);
            row_pop     = row_pop + PW'(row_mask[j]);
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            row_idx            <= '0;
            pass_removed       <= '0;
            first_commit       <= 1'b0;
            row_ready          <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            first_pass_removed <= '0;
            total_removed      <= '0;
            pass_count         <= '0;
`ifdef EXHAUST_PASS_LIMIT_EN
            limit_hit          <= 1'b0;
`endif
            // NOTE: grid and mask are flop arrays, not RAM macros, so clearing them in reset is legal.
            for (int i = 0; i < DEPTH; i++) begin
                grid[i] <= '0;
                mask[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state              <= S_LOAD;
                        row_idx            <= '0;
                        pass_removed       <= '0;
                        first_commit       <= 1'b1;
                        row_ready          <= 1'b1;
                        busy               <= 1'b1;
                        done               <= 1'b0;
                        first_pass_removed <= '0;
                        total_removed      <= '0;
                        pass_count         <= '0;
`ifdef EXHAUST_PASS_LIMIT_EN
                        limit_hit          <= 1'b0;
`endif
                        for (int i = 0; i < DEPTH; i++) mask[i] <= '0;
                    end
                end

                S_LOAD: begin
                    if (row_valid) begin
                        grid[row_idx] <= row_data;
                        if (row_idx == LAST_ROW) begin
                            state        <= S_SCAN;
                            row_idx      <= '0;
                            row_ready    <= 1'b0;
                            pass_removed <= '0;
                        end else begin
                            row_idx <= row_idx + RW'(1);
                        end
                    end
                end

                // Decisions use the start-of-pass grid; removals are only applied in COMMIT.
                S_SCAN: begin
                    mask[row_idx] <= row_mask;
                    pass_removed  <= pass_removed + CNT_W'(row_pop);
                    if (row_idx == LAST_ROW) begin
                        state <= S_COMMIT;
                    end else begin
                        row_idx <= row_idx + RW'(1);
                    end
                end

                S_COMMIT: begin
                    for (int i = 0; i < DEPTH; i++) grid[i] <= grid[i] & ~mask[i];
                    total_removed <= total_removed + pass_removed;
                    first_commit  <= 1'b0;
                    if (first_commit) first_pass_removed <= pass_removed;
                    if (pass_removed != '0) begin
                        pass_count <= pass_count + PASS_W'(1);
`ifdef EXHAUST_PASS_LIMIT_EN
                        if (pass_count == PASS_W'(MAX_PASSES - 1)) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            limit_hit <= 1'b1;
                        end else begin
                            state        <= S_SCAN;
                            row_idx      <= '0;
                            pass_removed <= '0;
                            for (int i = 0; i < DEPTH; i++) mask[i] <= '0;
                        end
`else
                        state        <= S_SCAN;
                        row_idx      <= '0;
                        pass_removed <= '0;
                        for (int i = 0; i < DEPTH; i++) mask[i] <= '0;
`endif
                    end else begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exhaustive_removal_ctrl.sv
// Directed bench for exhaustive_removal_ctrl: 3x3, 4x4 and 16x16 instances (plus a capped 3x3 one when EXHAUST_PASS_LIMIT_EN is defined).
module tb_exhaustive_removal_ctrl;

    localparam int NDUT = 4;
`ifdef EXHAUST_PASS_LIMIT_EN
    localparam int NUSED = 4;
`else
    localparam int NUSED = 3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NDUT-1:0] start_v;
    logic            row_valid;
    logic [15:0]     row_data;

    logic [NDUT-1:0] rdy, bsy, dn, lim;
    logic [8:0]      fpr  [NDUT];
    logic [8:0]      tot  [NDUT];
    logic [8:0]      pcnt [NDUT];

    logic [3:0] fp3, tot3, pc3;
    logic [4:0] fp4, tot4, pc4;
    logic [8:0] fp16, tot16, pc16;

    exhaustive_removal_ctrl #(.WIDTH(3), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .row_valid(row_valid),
        .row_ready(rdy[0]), .row_data(row_data[2:0]), .busy(bsy[0]), .done(dn[0]),
        .first_pass_removed(fp3), .total_removed(tot3), .pass_count(pc3)
`ifdef EXHAUST_PASS_LIMIT_EN
        , .limit_hit(lim[0])
`endif
    );

    exhaustive_removal_ctrl #(.WIDTH(4), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .row_valid(row_valid),
        .row_ready(rdy[1]), .row_data(row_data[3:0]), .busy(bsy[1]), .done(dn[1]),
        .first_pass_removed(fp4), .total_removed(tot4), .pass_count(pc4)
`ifdef EXHAUST_PASS_LIMIT_EN
        , .limit_hit(lim[1])
`endif
    );

    exhaustive_removal_ctrl #(.WIDTH(16), .DEPTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .row_valid(row_valid),
        .row_ready(rdy[2]), .row_data(row_data), .busy(bsy[2]), .done(dn[2]),
        .first_pass_removed(fp16), .total_removed(tot16), .pass_count(pc16)
`ifdef EXHAUST_PASS_LIMIT_EN
        , .limit_hit(lim[2])
`endif
    );

    assign fpr[0] = 9'(fp3);  assign tot[0] = 9'(tot3);  assign pcnt[0] = 9'(pc3);
    assign fpr[1] = 9'(fp4);  assign tot[1] = 9'(tot4);  assign pcnt[1] = 9'(pc4);
    assign fpr[2] = fp16;     assign tot[2] = tot16;     assign pcnt[2] = pc16;

`ifdef EXHAUST_PASS_LIMIT_EN
    logic [3:0] fpl, totl, pcl;
    exhaustive_removal_ctrl #(.WIDTH(3), .DEPTH(3), .MAX_PASSES(2)) u_dut_lim (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .row_valid(row_valid),
        .row_ready(rdy[3]), .row_data(row_data[2:0]), .busy(bsy[3]), .done(dn[3]),
        .first_pass_removed(fpl), .total_removed(totl), .pass_count(pcl),
        .limit_hit(lim[3])
    );
    assign fpr[3] = 9'(fpl);  assign tot[3] = 9'(totl);  assign pcnt[3] = 9'(pcl);
`else
    assign rdy[3] = 1'b0;  assign bsy[3] = 1'b0;  assign dn[3] = 1'b0;
    assign fpr[3] = '0;    assign tot[3] = '0;    assign pcnt[3] = '0;
    assign lim    = '0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        int          sel;
        int          depth;
        logic [255:0] grid;
        bit          stall;
        bit          poke;
        int          cyc;
        int          first;
        int          total;
        int          passes;
        bit          limit;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [255:0] uniform(input int d, input logic [15:0] val);
        logic [255:0] g;
        g = '0;
        for (int i = 0; i < d; i++) g[i*16 +: 16] = val;
        return g;
    endfunction

    function automatic vec_t mkv(input string name, input int sel, input int depth,
                                 input logic [255:0] grid, input bit stall, input bit poke,
                                 input int cyc, input int first, input int total,
                                 input int passes, input bit limit);
        vec_t v;
        v.name = name;  v.sel = sel;   v.depth = depth;  v.grid = grid;
        v.stall = stall; v.poke = poke; v.cyc = cyc;     v.first = first;
        v.total = total; v.passes = passes; v.limit = limit;
        return v;
    endfunction

    // Start, load (optionally with a toggling valid), then time the passes until done.
    task automatic run_vec(input vec_t v);
        int sel;
        int beats;
        int budget;
        int cyc;
        sel = v.sel;
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v = '0;
        beats  = 0;
        budget = 0;
        while (beats < v.depth && budget < 200) begin
            row_valid = v.stall ? ((budget % 2) == 1) : 1'b1;
            row_data  = v.grid[beats*16 +: 16];
            if (row_valid && rdy[sel]) beats++;
            budget++;
            @(posedge clk);
            if (beats < v.depth) @(negedge clk);
        end
        #1;
        check($sformatf("%s.beats", v.name), beats, v.depth);
        check($sformatf("%s.ready_after_load", v.name), int'(rdy[sel]), 0);
        row_valid = v.stall;
        cyc = 0;
        while (!dn[sel] && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            start_v[sel] = (v.poke && cyc == 3);
        end
        start_v   = '0;
        row_valid = 1'b0;
        check($sformatf("%s.cycles", v.name), cyc, v.cyc);
        check($sformatf("%s.busy", v.name), int'(bsy[sel]), 0);
        check($sformatf("%s.first", v.name), int'(fpr[sel]), v.first);
        check($sformatf("%s.total", v.name), int'(tot[sel]), v.total);
        check($sformatf("%s.passes", v.name), int'(pcnt[sel]), v.passes);
`ifdef EXHAUST_PASS_LIMIT_EN
        check($sformatf("%s.limit_hit", v.name), int'(lim[sel]), int'(v.limit));
`endif
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("%s.done_held", v.name), int'(dn[sel]), 1);
        check($sformatf("%s.total_held", v.name), int'(tot[sel]), v.total);
    endtask

    initial begin
        vec_t full3;
        full3 = mkv("full3", 0, 3, uniform(3, 16'h7), 1'b0, 1'b0, 16, 4, 9, 3, 1'b0);

        vecs.push_back(full3);
        vecs.push_back(mkv("full4_poke", 1, 4, uniform(4, 16'hF), 1'b0, 1'b1, 10, 4, 4, 1, 1'b0));
        vecs.push_back(mkv("zero16", 2, 16, '0, 1'b0, 1'b0, 17, 0, 0, 0, 1'b0));
        vecs.push_back(mkv("full3_stall", 0, 3, uniform(3, 16'h7), 1'b1, 1'b0, 16, 4, 9, 3, 1'b0));
        vecs.push_back(mkv("center3", 0, 3, {208'b0, 16'h0, 16'h2, 16'h0}, 1'b0, 1'b0, 8, 1, 1, 1, 1'b0));
        vecs.push_back(mkv("fff0_4", 1, 4, {192'b0, 16'h0, 16'hF, 16'hF, 16'hF}, 1'b0, 1'b0, 25, 4, 12, 4, 1'b0));
        vecs.push_back(mkv("full16", 2, 16, uniform(16, 16'hFFFF), 1'b0, 1'b0, 34, 4, 4, 1, 1'b0));
`ifdef EXHAUST_PASS_LIMIT_EN
        vecs.push_back(mkv("limit3", 3, 3, uniform(3, 16'h7), 1'b0, 1'b0, 8, 4, 8, 2, 1'b1));
`endif

        rst_n     = 1'b0;
        start_v   = '0;
        row_valid = 1'b0;
        row_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < NUSED; s++) begin
            check($sformatf("reset.busy%0d", s), int'(bsy[s]), 0);
            check($sformatf("reset.done%0d", s), int'(dn[s]), 0);
            check($sformatf("reset.ready%0d", s), int'(rdy[s]), 0);
            check($sformatf("reset.total%0d", s), int'(tot[s]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) run_vec(vecs[k]);

        // Reset during pass 2 of a 3x3 full run, then rerun the same grid.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v   = '0;
        row_valid = 1'b1;
        row_data  = 16'h7;
        repeat (3) @(posedge clk);
        #1;
        row_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midscan.total_before", int'(tot[0]), 4);
        check("midscan.busy_before", int'(bsy[0]), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midscan.busy", int'(bsy[0]), 0);
        check("midscan.done", int'(dn[0]), 0);
        check("midscan.ready", int'(rdy[0]), 0);
        check("midscan.first", int'(fpr[0]), 0);
        check("midscan.total", int'(tot[0]), 0);
        check("midscan.passes", int'(pcnt[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        full3.name = "after_reset";
        run_vec(full3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
